// File: rtl/spi_target.sv
// SPI target (mode 0) with a one-byte TX holding register and a byte receiver.
// SPIClk, nSPISel and SPIDi are synchronized into the Clk domain. All edge
// detection runs on the synchronized SPIClk.
// Optional feature macro: SPI_TARGET_BYTECOUNT_EN adds a saturating ByteCount output.
module spi_target #(
    parameter logic [7:0] FILL_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       SPIClk,
    input  logic       nSPISel,
    input  logic       SPIDi,
    output logic       SPIDo,
    output logic       SPIDoEn,
    output logic [7:0] RXData,
    output logic       RXValid,
    input  logic [7:0] TXData,
    input  logic       TXLoad,
    output logic       TXReady,
    output logic       TXUnderrun,
    output logic       Busy
`ifdef SPI_TARGET_BYTECOUNT_EN
    ,
    output logic [9:0] ByteCount
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACTIVE     = 2'd1,
        ST_WAIT_DESEL = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
    logic [SYNC_STAGES-1:0] di_sync_q, di_sync_d;
    logic [SYNC_STAGES-1:0] settle_q, settle_d;
    logic                   sclk_prev_q;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic [7:0]             hold_q, hold_d;
    logic                   hold_empty_q, hold_empty_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d;
    logic                   spido_q, spido_d;
    logic                   spidoen_q, spidoen_d;
    logic                   busy_q, busy_d;
    logic                   load_tx_s;
    logic                   sclk_s, sel_s, di_s, sclk_rise_s, sclk_fall_s;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign sel_s       = sel_sync_q[SYNC_STAGES-1];
    assign di_s        = di_sync_q[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_s & sclk_prev_q;

    assign SPIDo      = spido_q;
    assign SPIDoEn    = spidoen_q;
    assign RXData     = rx_data_q;
    assign RXValid    = rx_valid_q;
    assign TXReady    = hold_empty_q;
    assign TXUnderrun = underrun_q;
    assign Busy       = busy_q;

    // Synchronizer chains; settle_q fills with ones so WAIT_DESEL ignores the post-reset chain contents.
    always_comb begin
        sclk_sync_d    = sclk_sync_q;
        sel_sync_d     = sel_sync_q;
        di_sync_d      = di_sync_q;
        settle_d       = settle_q;
        sclk_sync_d[0] = SPIClk;
        sel_sync_d[0]  = nSPISel;
        di_sync_d[0]   = SPIDi;
        settle_d[0]    = 1'b1;
        for (int i = SYNC_STAGES - 1; i > 0; i--) begin
            sclk_sync_d[i] = sclk_sync_q[i-1];
            sel_sync_d[i]  = sel_sync_q[i-1];
            di_sync_d[i]   = di_sync_q[i-1];
            settle_d[i]    = settle_q[i-1];
        end
    end

    // Transfer state machine, shift registers and TX holding register next-state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        hold_d       = hold_q;
        hold_empty_d = hold_empty_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        underrun_d   = 1'b0;
        load_tx_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sel_s) begin
                    state_d    = ST_ACTIVE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 7'd0;
                    load_tx_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (sel_s) begin
                    // Deselect wins over any edge seen in the same cycle; partial byte dropped.
                    state_d    = ST_IDLE;
                    bit_cnt_d  = 3'd0;
                    rx_shift_d = 7'd0;
                end else if (sclk_rise_s) begin
                    rx_shift_d = {rx_shift_q[5:0], di_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q, di_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_valid_d = 1'b0;
                    end
                end else if (sclk_fall_s) begin
                    if (bit_cnt_q == 3'd0) begin
                        load_tx_s = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_WAIT_DESEL: begin
                if (settle_q[SYNC_STAGES-1] && sel_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DESEL;
                end
            end
            default: begin
                state_d = ST_WAIT_DESEL;
            end
        endcase
        // Byte-boundary load uses the holding state as it was before this cycle.
        if (load_tx_s) begin
            if (!hold_empty_q) begin
                tx_shift_d   = hold_q;
                hold_empty_d = 1'b1;
            end else begin
                tx_shift_d = FILL_BYTE;
                underrun_d = 1'b1;
            end
        end else begin
            underrun_d = 1'b0;
        end
        if (TXLoad && hold_empty_q) begin
            hold_d       = TXData;
            hold_empty_d = 1'b0;
        end else begin
            hold_d = hold_d;
        end
        spidoen_d = (state_d == ST_ACTIVE);
        busy_d    = (state_d == ST_ACTIVE);
        spido_d   = spidoen_d & tx_shift_d[7];
    end

    // State and data registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q      <= ST_WAIT_DESEL;
            sclk_sync_q  <= '0;
            sel_sync_q   <= '1;
            di_sync_q    <= '0;
            settle_q     <= '0;
            sclk_prev_q  <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 7'd0;
            tx_shift_q   <= 8'd0;
            hold_q       <= 8'd0;
            hold_empty_q <= 1'b1;
            rx_data_q    <= 8'h00;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            spido_q      <= 1'b0;
            spidoen_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sclk_sync_q  <= sclk_sync_d;
            sel_sync_q   <= sel_sync_d;
            di_sync_q    <= di_sync_d;
            settle_q     <= settle_d;
            sclk_prev_q  <= sclk_s;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            hold_q       <= hold_d;
            hold_empty_q <= hold_empty_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            underrun_q   <= underrun_d;
            spido_q      <= spido_d;
            spidoen_q    <= spidoen_d;
            busy_q       <= busy_d;
        end
    end

`ifdef SPI_TARGET_BYTECOUNT_EN
    logic [9:0] byte_cnt_q, byte_cnt_d;

    assign ByteCount = byte_cnt_q;

    // Byte counter: cleared on select, counts completed bytes, saturates at 1023.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (state_q == ST_IDLE && state_d == ST_ACTIVE) begin
            byte_cnt_d = 10'd0;
        end else if (rx_valid_d && byte_cnt_q != 10'd1023) begin
            byte_cnt_d = byte_cnt_q + 10'd1;
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Byte counter register.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            byte_cnt_q <= 10'd0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end
`endif

endmodule
